key_event_ctrl: RTL

Parametrised keyboard event and interrupt controller between the PS/2 keyboard reader and the CPU interrupt inputs. It edge-detects key presses and queues scan codes in a DEPTH-entry FIFO, so bursts of keys are not lost while the CPU services an interrupt. It drives a level IRQ while events are pending and presents the oldest code as interrupt data. Optionally, it decodes hot keys that select the debug display mode.

---
 rtl/key_event_pkg.sv | 44 ++++
 rtl/key_fifo.sv | 62 ++++++
 rtl/key_event_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared constants and types for the keyboard event controller: hot-key scan
// codes, the display-mode enum and the hot-key decode helper.
package key_event_pkg;

    localparam int HK_CODE_W = 9;

    localparam logic [HK_CODE_W-1:0] KEY_P = 9'h04D;
    localparam logic [HK_CODE_W-1:0] KEY_A = 9'h01C;
    localparam logic [HK_CODE_W-1:0] KEY_B = 9'h032;
    localparam logic [HK_CODE_W-1:0] KEY_C = 9'h021;
    localparam logic [HK_CODE_W-1:0] KEY_R = 9'h02D;
    localparam logic [HK_CODE_W-1:0] KEY_D = 9'h023;
    localparam logic [HK_CODE_W-1:0] KEY_S = 9'h01B;
    localparam logic [HK_CODE_W-1:0] KEY_F = 9'h02B;
    localparam logic [HK_CODE_W-1:0] KEY_I = 9'h043;

    typedef enum logic [2:0] {
        MODE_PC, MODE_A, MODE_B, MODE_C, MODE_ADDR, MODE_DATA, MODE_STATUS, MODE_PC2
    } disp_mode_e;

    typedef struct packed {
        logic       hit;
        disp_mode_e mode;
    } hot_key_t;

    function automatic hot_key_t hot_key_decode(input logic [HK_CODE_W-1:0] code);
        hot_key_t r;
        r.hit  = 1'b1;
        r.mode = MODE_PC;
        case (code)
            KEY_P:   r.mode = MODE_PC;
            KEY_A:   r.mode = MODE_A;
            KEY_B:   r.mode = MODE_B;
            KEY_C:   r.mode = MODE_C;
            KEY_R:   r.mode = MODE_ADDR;
            KEY_D:   r.mode = MODE_DATA;
            KEY_S:   r.mode = MODE_STATUS;
            KEY_F:   r.mode = MODE_PC2;
            default: r.hit  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Scan-code FIFO: DEPTH entries, simultaneous push/pop, and a full-FIFO
// policy that either drops the new code or overwrites the oldest one.
module key_fifo
    import key_event_pkg::*;
#(
    parameter int W        = 9,
    parameter int DEPTH    = 8,
    parameter bit DROP_OLD = 1'b0
) (
    input  logic                     fastClk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_adv_rd;

    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = pop && (r_count != '0);
    // A full write only lands when a slot is freed this cycle or the oldest entry is sacrificed.
    assign w_write  = push && (!w_full || w_pop || DROP_OLD);
    assign w_adv_rd = w_pop || (push && w_full && DROP_OLD);
    assign ovf      = push && w_full && !w_pop;

    // NOTE: storage has no reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge fastClk) begin
        if (w_write) r_mem[r_wr_ptr] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_adv_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_write && !w_adv_rd)      r_count <= r_count + 1'b1;
            else if (w_adv_rd && !w_write) r_count <= r_count - 1'b1;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/key_event_ctrl.sv
// Keyboard event / interrupt controller: key-press edge detect, scan-code FIFO,
// level IRQ and sticky overflow. Hot-key mode decode is compiled in by KEY_EVENT_HOTKEY_EN.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int CODE_W       = 9,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 8,
    parameter int OVF_DROP_OLD = 0
) (
    input  logic                   fastClk,
    input  logic                   rst,
    input  logic [CODE_W-1:0]      keyCode,
    input  logic                   keyPressed,
    input  logic                   irqMode,
    input  logic                   intEn,
    input  logic                   irqAck,
    input  logic                   ovfClr,
    output logic                   irq,
    output logic [DATA_W-1:0]      intData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [2:0]             mode
);

    logic              r_prev_pressed;
    logic              r_overflow;
    logic              w_event;
    logic              w_push;
    logic              w_ovf;
    logic [CODE_W-1:0] w_head;

    assign w_event = keyPressed && !r_prev_pressed;

    key_fifo #(
        .W        (CODE_W),
        .DEPTH    (DEPTH),
        .DROP_OLD (OVF_DROP_OLD != 0)
    ) u_fifo (
        .fastClk (fastClk),
        .rst     (rst),
        .push    (w_push),
        .pop     (irqAck),
        .din     (keyCode),
        .head    (w_head),
        .count   (count),
        .ovf     (w_ovf)
    );

    // prevPressed resets high so a key held through reset is not seen as a new press.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            r_prev_pressed <= 1'b1;
            r_overflow     <= 1'b0;
        end else begin
            r_prev_pressed <= keyPressed;
            if (w_ovf)       r_overflow <= 1'b1;
            else if (ovfClr) r_overflow <= 1'b0;
        end
    end

`ifdef KEY_EVENT_HOTKEY_EN
    disp_mode_e r_mode;
    hot_key_t   w_hk;
    logic       w_hi_zero;
    logic       w_mode_we;

    assign w_hi_zero = ((keyCode >> HK_CODE_W) == '0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_push    = 1'b0;
        w_mode_we = 1'b0;
        w_hk      = hot_key_decode(HK_CODE_W'(keyCode));
        if (w_event) begin
            if (irqMode)                    w_push    = 1'b1;
            else if (w_hi_zero && w_hk.hit) w_mode_we = 1'b1;
            else if (keyCode == CODE_W'(KEY_I)) w_push = 1'b1;
        end
    end

    always_ff @(posedge fastClk) begin
        if (rst)            r_mode <= MODE_PC;
        else if (w_mode_we) r_mode <= w_hk.mode;
    end

    assign mode = r_mode;
`else
    logic w_unused;
    assign w_unused = irqMode;
    assign w_push   = w_event;
    assign mode     = 3'd0;
`endif

    assign irq      = intEn && (count != '0);
    assign intData  = (count != '0) ? DATA_W'(w_head) : '0;
    assign overflow = r_overflow;

endmodule
